// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - three-unit completion FIFOs with round-robin register-file writeback
module writeback_arbiter #(
   parameter int DEPTH = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        am_wb_valid,
   input  logic [4:0]  am_wb_regdest,
   input  logic [31:0] am_wb_data,
   input  logic        am_wb_writereg,
   input  logic        mem_wb_valid,
   input  logic [4:0]  mem_wb_regdest,
   input  logic [31:0] mem_wb_data,
   input  logic        mem_wb_writereg,
   input  logic        mul_wb_valid,
   input  logic [4:0]  mul_wb_regdest,
   input  logic [31:0] mul_wb_data,
   input  logic        mul_wb_writereg,
   output logic        wb_am_ready,
   output logic        wb_mem_ready,
   output logic        wb_mul_ready,
   output logic [4:0]  wb_reg_writeaddr,
   output logic [31:0] wb_reg_writedata,
   output logic        wb_reg_enablewrite,
   output logic [4:0]  wb_sb_writeaddr,
   output logic [1:0]  wb_sb_registerunit,
   output logic        wb_sb_enablewrite
);

   // FIFO capacity; pointers are one bit wide, so only two entries are meaningful
   localparam logic [1:0] CAP = 2'(DEPTH);

   // unit index: 0 = am, 1 = mem, 2 = mul (same encoding as wb_sb_registerunit)
   logic [2:0]  in_valid;
   logic [2:0]  in_writereg;
   logic [4:0]  in_regdest [3];
   logic [31:0] in_data [3];

   logic [1:0]  count_q [3];
   logic [1:0]  count_d [3];
   logic        wr_ptr_q [3];
   logic        rd_ptr_q [3];
   logic [4:0]  regdest_q [3][2];
   logic [31:0] data_q [3][2];
   logic [1:0]  rr_ptr_q;

   logic [2:0]  ready;
   logic [2:0]  push;
   logic [2:0]  pop;
   logic        grant_valid;
   logic [1:0]  grant_unit;
   logic [2:0]  cand_sum;
   logic [1:0]  cand;

   logic [4:0]  waddr_q;
   logic [31:0] wdata_q;
   logic [1:0]  wunit_q;
   logic        strobe_q;

   assign in_valid      = {mul_wb_valid, mem_wb_valid, am_wb_valid};
   assign in_writereg   = {mul_wb_writereg, mem_wb_writereg, am_wb_writereg};
   assign in_regdest[0] = am_wb_regdest;
   assign in_regdest[1] = mem_wb_regdest;
   assign in_regdest[2] = mul_wb_regdest;
   assign in_data[0]    = am_wb_data;
   assign in_data[1]    = mem_wb_data;
   assign in_data[2]    = mul_wb_data;

   assign wb_am_ready  = ready[0];
   assign wb_mem_ready = ready[1];
   assign wb_mul_ready = ready[2];

   assign wb_reg_writeaddr   = waddr_q;
   assign wb_sb_writeaddr    = waddr_q;
   assign wb_reg_writedata   = wdata_q;
   assign wb_sb_registerunit = wunit_q;
   assign wb_reg_enablewrite = strobe_q;
   assign wb_sb_enablewrite  = strobe_q;

   // ready from the pre-edge count only; completions with no register target are accepted but dropped
   always_comb begin
      for (int u = 0; u < 3; u++) begin
         ready[u] = (count_q[u] < CAP);
         push[u]  = in_valid[u] & ready[u] & in_writereg[u] & (in_regdest[u] != 5'd0);
      end
   end

   // round-robin search from rr_ptr; walking offsets high-to-low lets the nearest candidate win
   always_comb begin
      grant_valid = 1'b0;
      grant_unit  = rr_ptr_q;
      cand_sum    = 3'd0;
      cand        = 2'd0;
      for (int k = 2; k >= 0; k--) begin
         cand_sum = {1'b0, rr_ptr_q} + 3'(k);
         if (cand_sum >= 3'd3) begin
            cand_sum = cand_sum - 3'd3;
         end
         cand = cand_sum[1:0];
         if (count_q[cand] != 2'd0) begin
            grant_valid = 1'b1;
            grant_unit  = cand;
         end
      end
      for (int u = 0; u < 3; u++) begin
         pop[u] = grant_valid && (grant_unit == 2'(u));
      end
   end

   // next occupancy: a push and pop in the same cycle cancel out
   always_comb begin
      for (int u = 0; u < 3; u++) begin
         count_d[u] = count_q[u] + {1'b0, push[u]} - {1'b0, pop[u]};
      end
   end

   // FIFO payload storage; contents are don't-care while the count says empty
   always_ff @(posedge clock) begin
      for (int u = 0; u < 3; u++) begin
         if (push[u]) begin
            regdest_q[u][wr_ptr_q[u]] <= in_regdest[u];
            data_q[u][wr_ptr_q[u]]    <= in_data[u];
         end
      end
   end

   // FIFO control, round-robin pointer and registered writeback outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int u = 0; u < 3; u++) begin
            count_q[u]  <= 2'd0;
            wr_ptr_q[u] <= 1'b0;
            rd_ptr_q[u] <= 1'b0;
         end
         rr_ptr_q <= 2'd0;
         waddr_q  <= 5'd0;
         wdata_q  <= 32'd0;
         wunit_q  <= 2'd0;
         strobe_q <= 1'b0;
      end else begin
         for (int u = 0; u < 3; u++) begin
            count_q[u] <= count_d[u];
            if (push[u]) begin
               wr_ptr_q[u] <= ~wr_ptr_q[u];
            end
            if (pop[u]) begin
               rd_ptr_q[u] <= ~rd_ptr_q[u];
            end
         end
         strobe_q <= grant_valid;
         if (grant_valid) begin
            rr_ptr_q <= (grant_unit == 2'd2) ? 2'd0 : grant_unit + 2'd1;
            waddr_q  <= regdest_q[grant_unit][rd_ptr_q[grant_unit]];
            wdata_q  <= data_q[grant_unit][rd_ptr_q[grant_unit]];
            wunit_q  <= grant_unit;
         end
      end
   end

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - directed checks for writeback_arbiter
module tb_writeback_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        am_wb_valid, mem_wb_valid, mul_wb_valid;
   logic [4:0]  am_wb_regdest, mem_wb_regdest, mul_wb_regdest;
   logic [31:0] am_wb_data, mem_wb_data, mul_wb_data;
   logic        am_wb_writereg, mem_wb_writereg, mul_wb_writereg;
   logic        wb_am_ready, wb_mem_ready, wb_mul_ready;
   logic [4:0]  wb_reg_writeaddr, wb_sb_writeaddr;
   logic [31:0] wb_reg_writedata;
   logic        wb_reg_enablewrite, wb_sb_enablewrite;
   logic [1:0]  wb_sb_registerunit;

   int passed = 0;
   int total  = 0;

   writeback_arbiter #(.DEPTH(2)) dut (
      .clock              (clock),
      .reset              (reset),
      .am_wb_valid        (am_wb_valid),
      .am_wb_regdest      (am_wb_regdest),
      .am_wb_data         (am_wb_data),
      .am_wb_writereg     (am_wb_writereg),
      .mem_wb_valid       (mem_wb_valid),
      .mem_wb_regdest     (mem_wb_regdest),
      .mem_wb_data        (mem_wb_data),
      .mem_wb_writereg    (mem_wb_writereg),
      .mul_wb_valid       (mul_wb_valid),
      .mul_wb_regdest     (mul_wb_regdest),
      .mul_wb_data        (mul_wb_data),
      .mul_wb_writereg    (mul_wb_writereg),
      .wb_am_ready        (wb_am_ready),
      .wb_mem_ready       (wb_mem_ready),
      .wb_mul_ready       (wb_mul_ready),
      .wb_reg_writeaddr   (wb_reg_writeaddr),
      .wb_reg_writedata   (wb_reg_writedata),
      .wb_reg_enablewrite (wb_reg_enablewrite),
      .wb_sb_writeaddr    (wb_sb_writeaddr),
      .wb_sb_registerunit (wb_sb_registerunit),
      .wb_sb_enablewrite  (wb_sb_enablewrite)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      am_wb_valid = 0; am_wb_regdest = 0; am_wb_data = 0; am_wb_writereg = 0;
      mem_wb_valid = 0; mem_wb_regdest = 0; mem_wb_data = 0; mem_wb_writereg = 0;
      mul_wb_valid = 0; mul_wb_regdest = 0; mul_wb_data = 0; mul_wb_writereg = 0;
   endtask

   task automatic offer(input int unit, input logic [4:0] rd, input logic [31:0] d, input logic wr);
      case (unit)
         0: begin am_wb_valid = 1; am_wb_regdest = rd; am_wb_data = d; am_wb_writereg = wr; end
         1: begin mem_wb_valid = 1; mem_wb_regdest = rd; mem_wb_data = d; mem_wb_writereg = wr; end
         default: begin mul_wb_valid = 1; mul_wb_regdest = rd; mul_wb_data = d; mul_wb_writereg = wr; end
      endcase
   endtask

   task automatic expect_write(input string tag, input logic [4:0] rd, input logic [31:0] d, input logic [1:0] unit);
      check({tag, "_regwe"}, 32'(wb_reg_enablewrite), 32'd1);
      check({tag, "_sbwe"}, 32'(wb_sb_enablewrite), 32'd1);
      check({tag, "_addr"}, 32'(wb_reg_writeaddr), 32'(rd));
      check({tag, "_sbaddr"}, 32'(wb_sb_writeaddr), 32'(rd));
      check({tag, "_data"}, wb_reg_writedata, d);
      check({tag, "_unit"}, 32'(wb_sb_registerunit), 32'(unit));
   endtask

   task automatic expect_idle(input string tag);
      check({tag, "_regwe"}, 32'(wb_reg_enablewrite), 32'd0);
      check({tag, "_sbwe"}, 32'(wb_sb_enablewrite), 32'd0);
   endtask

   task automatic expect_reset_outputs(input string tag);
      expect_idle(tag);
      check({tag, "_addr"}, 32'(wb_reg_writeaddr), 32'd0);
      check({tag, "_sbaddr"}, 32'(wb_sb_writeaddr), 32'd0);
      check({tag, "_data"}, wb_reg_writedata, 32'd0);
      check({tag, "_unit"}, 32'(wb_sb_registerunit), 32'd0);
      check({tag, "_ready"}, {29'd0, wb_mul_ready, wb_mem_ready, wb_am_ready}, 32'h7);
   endtask

   initial begin
      idle();
      reset = 0;
      #2;
      expect_reset_outputs("rst");
      @(posedge clock);
      #3;
      reset = 1;

      // all three units at once from rr=am: retire am, mem, mul in order
      offer(0, 5'd1, 32'h11111111, 1);
      offer(1, 5'd2, 32'h22222222, 1);
      offer(2, 5'd3, 32'h33333333, 1);
      step();
      idle();
      expect_idle("rr3_nobypass");
      step(); expect_write("rr3_w1", 5'd1, 32'h11111111, 2'd0);
      step(); expect_write("rr3_w2", 5'd2, 32'h22222222, 2'd1);
      step(); expect_write("rr3_w3", 5'd3, 32'h33333333, 2'd2);
      step(); expect_idle("rr3_end");
      check("rr3_hold_addr", 32'(wb_reg_writeaddr), 32'd3);

      // rr_ptr must be back at am: am beats mul
      offer(0, 5'd10, 32'hAAAA000A, 1);
      offer(2, 5'd12, 32'hCCCC000C, 1);
      step();
      idle();
      step(); expect_write("rr2_am", 5'd10, 32'hAAAA000A, 2'd0);
      step(); expect_write("rr2_mul", 5'd12, 32'hCCCC000C, 2'd2);
      step(); expect_idle("rr2_end");

      // single am completion, one-cycle latency, strobe drops afterwards
      offer(0, 5'd5, 32'hDEADBEEF, 1);
      step();
      idle();
      expect_idle("single_lat");
      step(); expect_write("single", 5'd5, 32'hDEADBEEF, 2'd0);
      step(); expect_idle("single_end");
      check("single_hold_data", wb_reg_writedata, 32'hDEADBEEF);

      // discarded completions: no FIFO slot, no strobe
      offer(1, 5'd9, 32'h99999999, 0);
      offer(0, 5'd0, 32'h12345678, 1);
      step();
      idle();
      check("discard_ready", {29'd0, wb_mul_ready, wb_mem_ready, wb_am_ready}, 32'h7);
      step(); expect_idle("discard_1");
      step(); expect_idle("discard_2");
      check("discard_hold_addr", 32'(wb_reg_writeaddr), 32'd5);

      // count=1 enqueue+dequeue in the same cycle keeps order 7 then 8
      offer(0, 5'd7, 32'h00000007, 1);
      step();
      expect_idle("ed_first");
      offer(0, 5'd8, 32'h00000008, 1);
      step();
      idle();
      expect_write("ed_w7", 5'd7, 32'h00000007, 2'd0);
      check("ed_ready", 32'(wb_am_ready), 32'd1);
      step(); expect_write("ed_w8", 5'd8, 32'h00000008, 2'd0);
      step(); expect_idle("ed_end");

      // mul backpressure: third offer held while full, accepted after count drops
      offer(0, 5'd20, 32'h00001020, 1);
      offer(1, 5'd21, 32'h00001021, 1);
      offer(2, 5'd22, 32'h00001022, 1);
      step();
      idle();
      offer(2, 5'd23, 32'h00001023, 1);
      step();
      expect_write("bp_w21", 5'd21, 32'h00001021, 2'd1);
      check("bp_full_ready", 32'(wb_mul_ready), 32'd0);
      offer(2, 5'd25, 32'h00001025, 1);
      step();
      expect_write("bp_w22", 5'd22, 32'h00001022, 2'd2);
      check("bp_drain_ready", 32'(wb_mul_ready), 32'd1);
      step();
      idle();
      expect_write("bp_w20", 5'd20, 32'h00001020, 2'd0);
      check("bp_refull_ready", 32'(wb_mul_ready), 32'd0);
      step(); expect_write("bp_w23", 5'd23, 32'h00001023, 2'd2);
      step(); expect_write("bp_w25", 5'd25, 32'h00001025, 2'd2);
      step(); expect_idle("bp_end");

      // reset mid-cycle with entries queued: outputs clear at once, nothing stale afterwards
      offer(0, 5'd14, 32'h00000040, 1);
      offer(1, 5'd15, 32'h00000041, 1);
      offer(2, 5'd16, 32'h00000042, 1);
      step();
      offer(0, 5'd17, 32'h00000043, 1);
      offer(1, 5'd18, 32'h00000044, 1);
      offer(2, 5'd19, 32'h00000045, 1);
      step();
      idle();
      expect_write("mr_pre", 5'd14, 32'h00000040, 2'd0);
      #2;
      reset = 0;
      #1;
      expect_reset_outputs("mr_async");
      @(posedge clock);
      #3;
      expect_reset_outputs("mr_held");
      reset = 1;
      step(); expect_idle("mr_post1");
      check("mr_post_ready", {29'd0, wb_mul_ready, wb_mem_ready, wb_am_ready}, 32'h7);
      step(); expect_idle("mr_post2");
      step(); expect_idle("mr_post3");

      // first grant after reset searches from am
      offer(1, 5'd31, 32'h00000031, 1);
      offer(0, 5'd30, 32'h00000030, 1);
      step();
      idle();
      step(); expect_write("post_am", 5'd30, 32'h00000030, 2'd0);
      step(); expect_write("post_mem", 5'd31, 32'h00000031, 2'd1);
      step(); expect_idle("post_end");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter DEPTH, default 2, meaning entries per functional-unit completion FIFO; the design SHALL support only DEPTH = 2.
REQ-002 clock  input  1  rising-edge clock.
REQ-003 reset  input  1  reset, asynchronous, active-low.
REQ-004 For each unit u in {am, mem, mul}: u_wb_valid  input  1  completion offered by unit u.
REQ-005 For each unit u: u_wb_regdest  input  5  destination register.
REQ-006 For each unit u: u_wb_data  input  32  result.
REQ-007 For each unit u: u_wb_writereg  input  1  result targets the register file.
REQ-008 For each unit u: wb_u_ready  output  1  unit u's FIFO can accept this cycle.
REQ-009 wb_reg_writeaddr  output  5  register-file write address.
REQ-010 wb_reg_writedata  output  32  register-file write data.
REQ-011 wb_reg_enablewrite  output  1  register-file write strobe.
REQ-012 wb_sb_writeaddr  output  5  scoreboard entry to clear.
REQ-013 wb_sb_registerunit  output  2  retiring unit: 00 am, 01 mem, 10 mul.
REQ-014 wb_sb_enablewrite  output  1  scoreboard clear strobe.

Function
REQ-015 A completion SHALL be accepted on a rising edge only when u_wb_valid = 1 and wb_u_ready = 1.
REQ-016 wb_u_ready SHALL equal (FIFO count < 2), using the count held before the edge; a full FIFO deasserts ready even if it dequeues in the same cycle.
REQ-017 An accepted completion with u_wb_writereg = 0 or u_wb_regdest = 0 SHALL be discarded and SHALL NOT occupy a FIFO slot.
REQ-018 All other accepted completions SHALL be enqueued in that unit's FIFO.
REQ-019 Each FIFO SHALL be first-in first-out, with a 2-bit count saturating at 2.
REQ-020 Simultaneous enqueue and dequeue on a FIFO holding 1 entry SHALL leave count = 1 with correct ordering.
REQ-021 Each cycle the arbiter SHALL grant at most one non-empty FIFO, chosen round-robin: search starts at rr_ptr, order am -> mem -> mul, cyclic.
REQ-022 After a grant, rr_ptr SHALL become (granted unit + 1) mod 3.
REQ-023 With no grant, rr_ptr SHALL be unchanged.
REQ-024 The rr_ptr encoding SHALL match REQ-013; value 11 is unreachable.
REQ-025 An entry enqueued at edge N SHALL NOT be granted before the cycle following edge N; there is no bypass.
REQ-026 The granted head entry SHALL be dequeued at edge N+1.
REQ-027 At edge N+1 the registered outputs SHALL take wb_reg_writeaddr = wb_sb_writeaddr = regdest, wb_reg_writedata = data, wb_sb_registerunit = unit, and wb_reg_enablewrite = wb_sb_enablewrite = 1.
REQ-028 Minimum latency from acceptance to write strobe SHALL be one cycle, i.e. outputs are valid for the cycle after edge N+1.
REQ-029 In any cycle without a grant, both strobes SHALL be 0 at the next edge; address, data and unit outputs SHALL hold their last values.
REQ-030 Both strobes SHALL always be equal.
REQ-031 Throughput SHALL be one retirement per cycle when any FIFO is non-empty.
REQ-032 Two in-flight completions to the same regdest from different units are excluded by issue-time hazard stalls; the block SHALL NOT reorder or check for them.
REQ-033 All FIFO storage, counts, rr_ptr and outputs SHALL be registered; wb_u_ready SHALL be the only combinational outputs, derived from counts only.

Reset
REQ-034 On reset low, asynchronously: all FIFO counts = 0, rr_ptr = 00, all strobes = 0, wb_reg_writeaddr = wb_sb_writeaddr = 0, wb_reg_writedata = 0, wb_sb_registerunit = 00.
REQ-035 Entries in flight at reset assertion SHALL be lost; wb_u_ready SHALL be 1 for all units while reset is low.
REQ-036 After reset release, the first grant SHALL search from am.

Verification
REQ-037 Single am completion (regdest = 5, data = 0xDEADBEEF, writereg = 1) accepted at edge 1 -> after edge 2: writeaddr = 5, writedata = 0xDEADBEEF, registerunit = 00, both strobes = 1; after edge 3: strobes = 0.
REQ-038 am, mem and mul each complete at edge 1 (regdest 1/2/3), rr_ptr = 00 -> writes 1, 2, 3 after edges 2, 3, 4; rr_ptr = 00 afterwards.
REQ-039 mul offers completions back-to-back with no grants possible (am and mem kept non-empty) -> wb_mul_ready drops to 0 after two accepts; a third offer is held, not lost, and accepted the cycle after the count falls to 1.
REQ-040 mem completion with writereg = 0, and am completion with regdest = 0 -> both accepted, FIFOs stay empty, no strobe is ever asserted.
REQ-041 FIFO at count = 1 enqueues and dequeues in the same cycle -> count stays 1; retired order matches arrival order (regdest 7 then 8).
REQ-042 Reset asserted mid-cycle with 2 entries queued per unit -> outputs zero immediately; after release no stale write occurs and all ready = 1.
